// File: rtl/stoch_to_bin_count.sv
// Stochastic-to-binary decoder: counts ones of a qualified bitstream over a WINDOW-sample window.
// Define S2B_BIPOLAR_EN for bipolar output (2*ones - window); the default build is unipolar.
module stoch_to_bin_count #(
    parameter int CW = 16
) (
    input  logic          TRIG,
    input  logic          RESET,
    input  logic          START,
    input  logic [CW-1:0] WINDOW,
    input  logic          IN_BIT,
    input  logic          IN_EN,
    output logic          BUSY,
    output logic          OUT_VALID,
    input  logic          OUT_READY,
    output logic [CW:0]   COUNT
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_COUNT,
        S_DONE
    } state_t;

    state_t        state;
    logic [CW-1:0] remaining;
    logic [CW-1:0] acc;
    logic [CW-1:0] acc_next;
    logic [CW:0]   result;
    logic [CW:0]   count_q;
    logic          busy_q;
    logic          valid_q;
    logic          accept;
    logic          last_sample;

`ifdef S2B_BIPOLAR_EN
    logic [CW-1:0] win_q;
`endif

    // A new window is accepted from IDLE, or from DONE only together with the result handshake.
    assign accept      = START && ((state == S_IDLE) || ((state == S_DONE) && OUT_READY));
    assign acc_next    = acc + CW'(IN_BIT);
    assign last_sample = IN_EN && (remaining == CW'(1));

`ifdef S2B_BIPOLAR_EN
    // Two's-complement bipolar value; acc_next <= win_q so the result stays within [-win_q, +win_q].
    assign result = {acc_next, 1'b0} - {1'b0, win_q};
`else
    assign result = {1'b0, acc_next};
`endif

    // NOTE: every register here sits on the async reset, so an abort mid-window clears the
    // partial count and the result at once rather than on the next clock edge.
    always_ff @(posedge TRIG or posedge RESET) begin
        if (RESET) begin
            state     <= S_IDLE;
            remaining <= '0;
            acc       <= '0;
            count_q   <= '0;
            busy_q    <= 1'b0;
            valid_q   <= 1'b0;
`ifdef S2B_BIPOLAR_EN
            win_q     <= '0;
`endif
        end else begin
            case (state)
                S_IDLE, S_DONE: begin
                    if (accept) begin
                        remaining <= WINDOW;
                        acc       <= '0;
`ifdef S2B_BIPOLAR_EN
                        win_q     <= WINDOW;
`endif
                        if (WINDOW != '0) begin
                            state   <= S_COUNT;
                            busy_q  <= 1'b1;
                            valid_q <= 1'b0;
                        end else begin
                            // Empty window: result is zero in either coding.
                            state   <= S_DONE;
                            busy_q  <= 1'b0;
                            valid_q <= 1'b1;
                            count_q <= '0;
                        end
                    end else if ((state == S_DONE) && OUT_READY) begin
                        state   <= S_IDLE;
                        valid_q <= 1'b0;
                    end
                end

                S_COUNT: begin
                    // IN_EN low stalls the window; there is no timeout.
                    if (IN_EN) begin
                        acc       <= acc_next;
                        remaining <= remaining - CW'(1);
                        if (last_sample) begin
                            count_q <= result;
                            state   <= S_DONE;
                            busy_q  <= 1'b0;
                            valid_q <= 1'b1;
                        end
                    end
                end

                default: begin
                    state   <= S_IDLE;
                    busy_q  <= 1'b0;
                    valid_q <= 1'b0;
                end
            endcase
        end
    end

    assign BUSY      = busy_q;
    assign OUT_VALID = valid_q;
    assign COUNT     = count_q;

endmodule

// File: tb/tb_stoch_to_bin_count.sv
// Directed self-checking bench for stoch_to_bin_count; expectations follow S2B_BIPOLAR_EN.
module tb_stoch_to_bin_count;

    localparam int CW = 16;

    logic          TRIG = 1'b0;
    logic          RESET;
    logic          START;
    logic [CW-1:0] WINDOW;
    logic          IN_BIT;
    logic          IN_EN;
    logic          BUSY;
    logic          OUT_VALID;
    logic          OUT_READY;
    logic [CW:0]   COUNT;

    int n_assert = 0;
    int n_fail   = 0;

    always #5 TRIG = ~TRIG;

    stoch_to_bin_count #(.CW(CW)) dut (
        .TRIG      (TRIG),
        .RESET     (RESET),
        .START     (START),
        .WINDOW    (WINDOW),
        .IN_BIT    (IN_BIT),
        .IN_EN     (IN_EN),
        .BUSY      (BUSY),
        .OUT_VALID (OUT_VALID),
        .OUT_READY (OUT_READY),
        .COUNT     (COUNT)
    );

    task automatic check(input string tag, input logic [CW:0] obs, input logic [CW:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Inputs change and outputs are sampled 1 time unit after each rising edge.
    task automatic tick();
        @(posedge TRIG);
        #1;
    endtask

    // Reference encoding of a finished window from its ones count and length.
    function automatic logic [CW:0] enc(input int ones, input int win);
`ifdef S2B_BIPOLAR_EN
        return (CW+1)'(2 * ones - win);
`else
        return (CW+1)'(ones + 0 * win);
`endif
    endfunction

    logic [7:0] pat;
    logic [5:0] en_seq;
    logic [7:0] lfsr;
    int         ones;

    initial begin
        RESET = 1'b1; START = 1'b0; WINDOW = '0; IN_BIT = 1'b0; IN_EN = 1'b0; OUT_READY = 1'b0;

        // Reset state
        #12;
        check("rst_busy",  (CW+1)'(BUSY), 0);
        check("rst_valid", (CW+1)'(OUT_VALID), 0);
        check("rst_count", COUNT, 0);
        @(negedge TRIG);
        RESET = 1'b0;
        tick();

        // Window of 8 with pattern 1010_1010
        pat = 8'b1010_1010;
        START = 1'b1; WINDOW = 16'd8; IN_EN = 1'b1;
        tick();
        START = 1'b0;
        check("w8_busy", (CW+1)'(BUSY), 1);
        for (int i = 0; i < 8; i++) begin
            check("w8_valid_low", (CW+1)'(OUT_VALID), 0);
            IN_BIT = pat[7 - i];
            tick();
        end
        check("w8_valid", (CW+1)'(OUT_VALID), 1);
        check("w8_busy_low", (CW+1)'(BUSY), 0);
        check("w8_count", COUNT, enc(4, 8));
        OUT_READY = 1'b1;
        tick();
        OUT_READY = 1'b0;
        check("w8_hs_valid", (CW+1)'(OUT_VALID), 0);
        check("w8_idle_count_hold", COUNT, enc(4, 8));

        // Stall: WINDOW=4, IN_EN = 1,0,0,1,1,1
        en_seq = 6'b100111;
        START = 1'b1; WINDOW = 16'd4; IN_BIT = 1'b1; IN_EN = 1'b0;
        tick();
        START = 1'b0;
        for (int i = 0; i < 6; i++) begin
            IN_EN = en_seq[5 - i];
            tick();
            if (i == 2) check("stall_busy", (CW+1)'(BUSY), 1);
            if (i == 4) check("stall_valid_low", (CW+1)'(OUT_VALID), 0);
        end
        IN_EN = 1'b0;
        check("stall_valid", (CW+1)'(OUT_VALID), 1);
        check("stall_count", COUNT, 17'd4);

        // Backpressure: OUT_READY low for 10 cycles, START ignored
        START = 1'b1; WINDOW = 16'd3;
        for (int i = 0; i < 10; i++) begin
            tick();
            check("bp_valid", (CW+1)'(OUT_VALID), 1);
            check("bp_count", COUNT, 17'd4);
        end
        check("bp_busy", (CW+1)'(BUSY), 0);

        // Back-to-back: handshake with START, WINDOW=3 of zeros
        OUT_READY = 1'b1; IN_EN = 1'b1; IN_BIT = 1'b0;
        tick();
        START = 1'b0; OUT_READY = 1'b0;
        check("b2b_busy", (CW+1)'(BUSY), 1);
        check("b2b_valid_low", (CW+1)'(OUT_VALID), 0);
        check("b2b_count_hold", COUNT, 17'd4);
        tick(); tick();
        check("b2b_valid_early", (CW+1)'(OUT_VALID), 0);
        tick();
        check("b2b_valid", (CW+1)'(OUT_VALID), 1);
`ifdef S2B_BIPOLAR_EN
        check("b2b_count", COUNT, 17'h1FFFD);
`else
        check("b2b_count", COUNT, 17'd0);
`endif
        OUT_READY = 1'b1;
        tick();
        OUT_READY = 1'b0;

        // Short window of two ones so that the reset clearing COUNT is observable
        START = 1'b1; WINDOW = 16'd2; IN_BIT = 1'b1;
        tick();
        START = 1'b0;
        tick(); tick();
        check("pre_rst_count", COUNT, enc(2, 2));
        OUT_READY = 1'b1;
        tick();
        OUT_READY = 1'b0;

        // Reset mid-window with acc=5
        START = 1'b1; WINDOW = 16'd10;
        tick();
        START = 1'b0;
        repeat (5) tick();
        check("mid_busy", (CW+1)'(BUSY), 1);
        #2 RESET = 1'b1;
        #1;
        check("async_rst_busy",  (CW+1)'(BUSY), 0);
        check("async_rst_valid", (CW+1)'(OUT_VALID), 0);
        check("async_rst_count", COUNT, 0);
        #2 RESET = 1'b0;
        tick(); tick();
        check("post_rst_busy",  (CW+1)'(BUSY), 0);
        check("post_rst_valid", (CW+1)'(OUT_VALID), 0);
        START = 1'b1; WINDOW = 16'd1;
        tick();
        START = 1'b0;
        check("post_rst_start", (CW+1)'(BUSY), 1);
        tick();
        check("w1_valid", (CW+1)'(OUT_VALID), 1);
        check("w1_count", COUNT, enc(1, 1));
        OUT_READY = 1'b1;
        tick();
        OUT_READY = 1'b0;

        // WINDOW=0: result one cycle after START
        START = 1'b1; WINDOW = 16'd0;
        tick();
        START = 1'b0;
        check("w0_valid", (CW+1)'(OUT_VALID), 1);
        check("w0_busy",  (CW+1)'(BUSY), 0);
        check("w0_count", COUNT, 17'd0);
        OUT_READY = 1'b1;
        tick();
        OUT_READY = 1'b0;

        // WINDOW=65535 of ones: no overflow
        START = 1'b1; WINDOW = 16'hFFFF; IN_BIT = 1'b1; IN_EN = 1'b1;
        tick();
        START = 1'b0;
        repeat (65534) tick();
        check("wmax_valid_low", (CW+1)'(OUT_VALID), 0);
        tick();
        check("wmax_valid", (CW+1)'(OUT_VALID), 1);
        check("wmax_count", COUNT, 17'h0FFFF);
        OUT_READY = 1'b1;
        tick();
        OUT_READY = 1'b0;

        // LFSR-limited stream, value 64 of 255, WINDOW=4096
        lfsr = 8'h01; ones = 0;
        START = 1'b1; WINDOW = 16'd4096;
        tick();
        START = 1'b0;
        for (int i = 0; i < 4096; i++) begin
            IN_BIT = (lfsr <= 8'd64);
            ones += int'(IN_BIT);
            lfsr = {lfsr[6:0], lfsr[7] ^ lfsr[5] ^ lfsr[4] ^ lfsr[3]};
            tick();
        end
        check("lfsr_valid", (CW+1)'(OUT_VALID), 1);
        check("lfsr_count", COUNT, enc(ones, 4096));
`ifndef S2B_BIPOLAR_EN
        check("lfsr_range", (CW+1)'((COUNT >= 17'd977) && (COUNT <= 17'd1079)), 1);
`endif
        OUT_READY = 1'b1;
        tick();
        OUT_READY = 1'b0;
        check("final_idle", (CW+1)'(OUT_VALID), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
